wb_shift_pipe: RTL and testbench
================================

WB_SHIFT_PIPE -- requirements
Module: wb_shift_pipe

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL expose these ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- stall  in  1  freeze all stages.
- flush  in  1  squash young stages.
- res_even  in  128 [0:127]  even-unit result.
- rt_even  in  7 [0:6]  even destination register.
- wr_even  in  1  even result writes register.
- lat_even  in  3  even latency, 1..7.
- res_odd, rt_odd, wr_odd, lat_odd  in  128/7/1/3  odd equivalents.
- fw_even_wb  out  [6:0][0:127]  even stage data, to forwarding.
- fw_addr_even_wb  out  [6:0][0:6]  even stage destinations.
- fw_write_even_wb  out  [6:0]  even stage write flags.
- fw_odd_wb, fw_addr_odd_wb, fw_write_odd_wb  out  same widths  odd equivalents.
- rf_we_even, rf_wa_even, rf_wd_even  out  1/7/128  even register-file write port.
- rf_we_odd, rf_wa_odd, rf_wd_odd  out  1/7/128  odd register-file write port.
- collision_even, collision_odd  out  1  insertion overwrote a live entry.
- wb_same_addr  out  1  both write ports target one register.

Function
REQ-003 SHALL hold two independent 7-stage shift registers, even and odd; each stage holds {data 128, addr 7, write 1}; fw_* outputs are the registered stage contents.
REQ-004 On each edge with stall=0, SHALL move stage i to stage i+1 for i=0..5; stage 0 loads {0,0,0}; stage 6 contents are discarded after being presented at write-back.
REQ-005 On the same edge, if wr_x=1 and lat_x is in 1..7, SHALL write {res_x, rt_x, 1} into stage lat_x-1 of pipe x, overriding the shifted-in value.
REQ-006 SHALL ignore insertion when lat_x=0 or wr_x=0; a zero-write entry is never inserted.
REQ-007 SHALL drive rf_we_x, rf_wa_x and rf_wd_x combinationally from stage 6 of pipe x (write, addr, data); write-back latency from insertion is 7-lat_x+1 edges.
REQ-008 With stall=1, SHALL hold every stage unchanged, ignore insertion, and drive rf_we_even and rf_we_odd to 0 so no duplicate write occurs.
REQ-009 With flush=1 and stall=0, SHALL shift as normal, then clear the write flags of resulting stages 0..2 in both pipes and suppress that cycle's insertion; data and addr bits are left unchanged.
REQ-010 With flush=1 and stall=1, flush SHALL take priority: clear write flags of stages 0..2 without shifting.
REQ-011 SHALL assert wb_same_addr combinationally when rf_we_even, rf_we_odd and rf_wa_even==rf_wa_odd; both write ports stay enabled, and the register file gives odd priority.

Reset
REQ-012 reset=1 at an edge SHALL clear all stage data, addr and write flags and both collision flags to 0, overriding stall, flush and insertion.
REQ-013 Reset asserted mid-operation SHALL discard all in-flight results; no rf_we_* is asserted in the cycle after reset.

Configuration
REQ-014 With macro WB_COLLISION_CHECK_EN defined, collision_x SHALL register 1 for one cycle when an insertion (REQ-005) overwrites a shifted-in entry whose write flag was 1; otherwise it is 0.
REQ-015 Without WB_COLLISION_CHECK_EN, collision_even and collision_odd SHALL be constant 0, with no detection logic; insertion still overrides per REQ-005.

Verification
REQ-016 Reset then idle: all fw_write_* = 0, rf_we_* = 0, all fw data = 0.
REQ-017 Insert even {res=128'hA5.., rt=7'd10, lat=2}: fw_write_even_wb[1]=1 after edge 1; rf_we_even=1 with rf_wa_even=10 after edge 6; gone after edge 7.
REQ-018 Insert odd rt=3 lat=1, then next cycle odd rt=4 lat=2: stage 1 holds rt=4; with WB_COLLISION_CHECK_EN, collision_odd=1 for one cycle; without it, collision_odd=0.
REQ-019 Entries in stages 1, 3 and 5, then flush: write flags of resulting stages 0..2 are 0; the entry now in stage 4 still writes back.
REQ-020 Entry in stage 6 with stall=1 for 3 cycles: rf_we=0 throughout; rf_we=1 on the first unstalled cycle only.
REQ-021 Even and odd entries both reach stage 6 with rt=20: wb_same_addr=1, and both rf_we_even and rf_we_odd are 1.

Source files
------------

// File: rtl/wb_shift_pipe.sv
// rtl/wb_shift_pipe.sv - dual 7-stage write-back shift pipe with forwarding taps; optional collision detect under WB_COLLISION_CHECK_EN

// One lane: a 7-deep shift register of {data, addr, write}. Results are
// dropped in at the stage matching their remaining latency so they all
// leave through stage 6 in program order.
module wb_shift_lane (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [0:127]      res_i,
  input  logic [0:6]        rt_i,
  input  logic              wr_i,
  input  logic [2:0]        lat_i,
  output logic [6:0][0:127] data_o,
  output logic [6:0][0:6]   addr_o,
  output logic [6:0]        write_o,
  output logic              collision_o
);

  logic [6:0][0:127] data_q, data_d;
  logic [6:0][0:6]   addr_q, addr_d;
  logic [6:0]        write_q, write_d;
  logic [2:0]        ins_idx;

`ifdef WB_COLLISION_CHECK_EN
  logic              coll_q, coll_d;
`endif

  assign ins_idx = lat_i - 3'd1;

  // Next-state: shift, then either squash young stages or insert the new result.
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    write_d = write_q;
`ifdef WB_COLLISION_CHECK_EN
    coll_d  = 1'b0;
`endif
    if (!stall_i) begin
      for (int i = 6; i >= 1; i--) begin
        data_d[i]  = data_q[i-1];
        addr_d[i]  = addr_q[i-1];
        write_d[i] = write_q[i-1];
      end
      data_d[0]  = '0;
      addr_d[0]  = '0;
      write_d[0] = 1'b0;
      if (flush_i) begin
        // Only the write flags are squashed; data/addr bits stay as shifted.
        write_d[2:0] = 3'b000;
      end else if (wr_i && (lat_i != 3'd0)) begin
`ifdef WB_COLLISION_CHECK_EN
        coll_d           = write_d[ins_idx];
`endif
        data_d[ins_idx]  = res_i;
        addr_d[ins_idx]  = rt_i;
        write_d[ins_idx] = 1'b1;
      end
    end else if (flush_i) begin
      // Frozen pipe still honours a flush of the young stages.
      write_d[2:0] = 3'b000;
    end
  end

  // Stage registers with synchronous reset overriding everything else.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      addr_q  <= '0;
      write_q <= '0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

`ifdef WB_COLLISION_CHECK_EN
  // One-cycle pulse when an insertion replaced a live shifted-in entry.
  always_ff @(posedge clock) begin
    if (reset) coll_q <= 1'b0;
    else       coll_q <= coll_d;
  end
  assign collision_o = coll_q;
`else
  assign collision_o = 1'b0;
`endif

  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign write_o = write_q;

endmodule

module wb_shift_pipe (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [0:127]      res_even,
  input  logic [0:6]        rt_even,
  input  logic              wr_even,
  input  logic [2:0]        lat_even,
  input  logic [0:127]      res_odd,
  input  logic [0:6]        rt_odd,
  input  logic              wr_odd,
  input  logic [2:0]        lat_odd,
  output logic [6:0][0:127] fw_even_wb,
  output logic [6:0][0:6]   fw_addr_even_wb,
  output logic [6:0]        fw_write_even_wb,
  output logic [6:0][0:127] fw_odd_wb,
  output logic [6:0][0:6]   fw_addr_odd_wb,
  output logic [6:0]        fw_write_odd_wb,
  output logic              rf_we_even,
  output logic [0:6]        rf_wa_even,
  output logic [0:127]      rf_wd_even,
  output logic              rf_we_odd,
  output logic [0:6]        rf_wa_odd,
  output logic [0:127]      rf_wd_odd,
  output logic              collision_even,
  output logic              collision_odd,
  output logic              wb_same_addr
);

  wb_shift_lane u_even (
    .clock       (clock),
    .reset       (reset),
    .stall_i     (stall),
    .flush_i     (flush),
    .res_i       (res_even),
    .rt_i        (rt_even),
    .wr_i        (wr_even),
    .lat_i       (lat_even),
    .data_o      (fw_even_wb),
    .addr_o      (fw_addr_even_wb),
    .write_o     (fw_write_even_wb),
    .collision_o (collision_even)
  );

  wb_shift_lane u_odd (
    .clock       (clock),
    .reset       (reset),
    .stall_i     (stall),
    .flush_i     (flush),
    .res_i       (res_odd),
    .rt_i        (rt_odd),
    .wr_i        (wr_odd),
    .lat_i       (lat_odd),
    .data_o      (fw_odd_wb),
    .addr_o      (fw_addr_odd_wb),
    .write_o     (fw_write_odd_wb),
    .collision_o (collision_odd)
  );

  // Write-back straight from stage 6; gated while stalled so a frozen
  // entry is written exactly once, on its first unstalled cycle.
  assign rf_we_even = fw_write_even_wb[6] & ~stall;
  assign rf_wa_even = fw_addr_even_wb[6];
  assign rf_wd_even = fw_even_wb[6];
  assign rf_we_odd  = fw_write_odd_wb[6] & ~stall;
  assign rf_wa_odd  = fw_addr_odd_wb[6];
  assign rf_wd_odd  = fw_odd_wb[6];

  // Same-register write from both ports; register file resolves to odd.
  assign wb_same_addr = rf_we_even & rf_we_odd & (rf_wa_even == rf_wa_odd);

endmodule

// File: tb/tb_wb_shift_pipe.sv
// tb/tb_wb_shift_pipe.sv - directed self-checking bench for wb_shift_pipe
module tb_wb_shift_pipe;

  logic              clock = 1'b0;
  logic              reset, stall, flush;
  logic [0:127]      res_even, res_odd;
  logic [0:6]        rt_even, rt_odd;
  logic              wr_even, wr_odd;
  logic [2:0]        lat_even, lat_odd;
  logic [6:0][0:127] fw_even_wb, fw_odd_wb;
  logic [6:0][0:6]   fw_addr_even_wb, fw_addr_odd_wb;
  logic [6:0]        fw_write_even_wb, fw_write_odd_wb;
  logic              rf_we_even, rf_we_odd;
  logic [0:6]        rf_wa_even, rf_wa_odd;
  logic [0:127]      rf_wd_even, rf_wd_odd;
  logic              collision_even, collision_odd, wb_same_addr;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_3C = {16{8'h3C}};

`ifdef WB_COLLISION_CHECK_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  wb_shift_pipe dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .res_even         (res_even),
    .rt_even          (rt_even),
    .wr_even          (wr_even),
    .lat_even         (lat_even),
    .res_odd          (res_odd),
    .rt_odd           (rt_odd),
    .wr_odd           (wr_odd),
    .lat_odd          (lat_odd),
    .fw_even_wb       (fw_even_wb),
    .fw_addr_even_wb  (fw_addr_even_wb),
    .fw_write_even_wb (fw_write_even_wb),
    .fw_odd_wb        (fw_odd_wb),
    .fw_addr_odd_wb   (fw_addr_odd_wb),
    .fw_write_odd_wb  (fw_write_odd_wb),
    .rf_we_even       (rf_we_even),
    .rf_wa_even       (rf_wa_even),
    .rf_wd_even       (rf_wd_even),
    .rf_we_odd        (rf_we_odd),
    .rf_wa_odd        (rf_wa_odd),
    .rf_wd_odd        (rf_wd_odd),
    .collision_even   (collision_even),
    .collision_odd    (collision_odd),
    .wb_same_addr     (wb_same_addr)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0;
    wr_even = 0; lat_even = 0; rt_even = 0; res_even = '0;
    wr_odd = 0;  lat_odd = 0;  rt_odd = 0;  res_odd = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ins_even(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] res);
    wr_even = 1; rt_even = rt; lat_even = lat; res_even = res;
  endtask

  task automatic ins_odd(input logic [6:0] rt, input logic [2:0] lat, input logic [127:0] res);
    wr_odd = 1; rt_odd = rt; lat_odd = lat; res_odd = res;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8; i++) step();
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    #1;

    // Reset then idle
    check("rst_fw_write_even", fw_write_even_wb, 0);
    check("rst_fw_write_odd", fw_write_odd_wb, 0);
    check("rst_rf_we_even", rf_we_even, 0);
    check("rst_rf_we_odd", rf_we_odd, 0);
    check("rst_fw_data_even", |fw_even_wb, 0);
    check("rst_fw_data_odd", |fw_odd_wb, 0);
    check("rst_coll_even", collision_even, 0);
    check("rst_same_addr", wb_same_addr, 0);

    // Even insertion lat=2: stage 1 after edge 1, write-back after edge 6
    ins_even(7'd10, 3'd2, PAT_A5);
    step(); idle();
    check("e1_fw_write", fw_write_even_wb, 7'b0000010);
    check("e1_addr1", fw_addr_even_wb[1], 10);
    check("e1_data1", fw_even_wb[1], PAT_A5);
    check("e1_rf_we", rf_we_even, 0);
    for (int e = 2; e <= 5; e++) begin
      step();
      check("e_mid_rf_we", rf_we_even, 0);
    end
    step();
    check("e6_rf_we", rf_we_even, 1);
    check("e6_rf_wa", rf_wa_even, 10);
    check("e6_rf_wd", rf_wd_even, PAT_A5);
    step();
    check("e7_rf_we", rf_we_even, 0);
    check("e7_fw_write", fw_write_even_wb, 0);

    // Odd overwrite of a live entry
    ins_odd(7'd3, 3'd1, 128'h1);
    step();
    check("o1_fw_write", fw_write_odd_wb, 7'b0000001);
    check("o1_coll", collision_odd, 0);
    ins_odd(7'd4, 3'd2, 128'h2);
    step(); idle();
    check("o2_addr1", fw_addr_odd_wb[1], 4);
    check("o2_data1", fw_odd_wb[1], 128'h2);
    check("o2_fw_write", fw_write_odd_wb, 7'b0000010);
    check("o2_coll", collision_odd, EXP_COLL);
    check("o2_coll_even", collision_even, 0);
    step();
    check("o3_coll", collision_odd, 0);
    drain();
    check("o_drained", fw_write_odd_wb, 0);

    // Entries at stages 1,3,5 then flush (with a suppressed insertion)
    ins_even(7'd21, 3'd2, 128'h21); step(); idle();
    step();
    ins_even(7'd22, 3'd2, 128'h22); step(); idle();
    step();
    ins_even(7'd23, 3'd2, 128'h23); step(); idle();
    check("f0_fw_write", fw_write_even_wb, 7'b0101010);
    flush = 1;
    ins_even(7'd30, 3'd1, 128'h30);
    step(); idle();
    check("f1_fw_write", fw_write_even_wb, 7'b1010000);
    check("f1_addr2_kept", fw_addr_even_wb[2], 23);
    check("f1_rf_we", rf_we_even, 1);
    check("f1_rf_wa", rf_wa_even, 21);
    step();
    check("f2_rf_we", rf_we_even, 0);
    step();
    check("f3_rf_we", rf_we_even, 1);
    check("f3_rf_wa", rf_wa_even, 22);
    check("f3_rf_wd", rf_wd_even, 128'h22);
    step();
    check("f4_fw_write", fw_write_even_wb, 0);

    // Flush while stalled: clear young flags, no shift
    ins_even(7'd11, 3'd1, 128'h11);
    ins_odd(7'd12, 3'd5, 128'h12);
    step(); idle();
    stall = 1; flush = 1;
    step(); idle();
    check("sf_fw_write_even", fw_write_even_wb, 0);
    check("sf_addr0_kept", fw_addr_even_wb[0], 11);
    check("sf_fw_write_odd", fw_write_odd_wb, 7'b0010000);
    drain();

    // Stage-6 entry held by stall
    ins_even(7'd40, 3'd7, PAT_3C);
    step(); idle();
    stall = 1;
    #1;
    check("s0_rf_we", rf_we_even, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("s_rf_we", rf_we_even, 0);
      check("s_held", fw_write_even_wb[6], 1);
    end
    stall = 0;
    #1;
    check("s_free_rf_we", rf_we_even, 1);
    check("s_free_rf_wd", rf_wd_even, PAT_3C);
    step();
    check("s_after_rf_we", rf_we_even, 0);

    // Same-address write-back from both pipes
    ins_even(7'd20, 3'd7, 128'hE);
    ins_odd(7'd20, 3'd7, 128'hF);
    step(); idle();
    check("sa_same", wb_same_addr, 1);
    check("sa_we_even", rf_we_even, 1);
    check("sa_we_odd", rf_we_odd, 1);
    ins_even(7'd20, 3'd7, 128'hE);
    ins_odd(7'd21, 3'd7, 128'hF);
    step(); idle();
    check("sa_diff", wb_same_addr, 0);
    check("sa_diff_we_odd", rf_we_odd, 1);
    step();
    check("sa_none", wb_same_addr, 0);

    // Reset mid-operation discards in-flight results
    ins_even(7'd50, 3'd3, 128'h50);
    ins_odd(7'd51, 3'd7, 128'h51);
    step();
    reset = 1; stall = 1; flush = 1;
    step();
    reset = 0; idle();
    #1;
    check("mr_fw_write_even", fw_write_even_wb, 0);
    check("mr_fw_write_odd", fw_write_odd_wb, 0);
    check("mr_rf_we_odd", rf_we_odd, 0);
    check("mr_addr_even", |fw_addr_even_wb, 0);
    check("mr_data_odd", |fw_odd_wb, 0);
    check("mr_coll_odd", collision_odd, 0);
    for (int c = 0; c < 7; c++) begin
      step();
      check("mr_rf_we_even", rf_we_even, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
